// File: rtl/pc_register_pkg.sv
// Shared core constants for the fetch stage: datapath width and the address
// the core starts fetching from after reset.
package pc_register_pkg;

    // Architectural address width (RV32).
    localparam int unsigned CORE_XLEN = 32;

    // First instruction address after reset.
    localparam logic [CORE_XLEN-1:0] CORE_RESET_VECTOR = 32'h0000_0000;

endpackage : pc_register_pkg

// File: rtl/pc_register.sv
// Program counter for the fetch stage. Holds the address of the instruction
// being fetched; loads the next PC when enabled and holds it otherwise so the
// hazard unit can stall fetch. The output comes straight from the register.
module pc_register
    import pc_register_pkg::*;
#(
    parameter int unsigned           XLEN         = CORE_XLEN,
    parameter logic [XLEN-1:0]       RESET_VECTOR = XLEN'(CORE_RESET_VECTOR)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_write_en,
    input  logic [XLEN-1:0] pc_next,
    output logic [XLEN-1:0] pc_out
);

    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] pc_q;

    // Next-state selection: reset wins, then load, otherwise hold (stall).
    always_comb begin
        // NOTE: pc_d gets a default before any branch, so no path through this
        // block leaves it unassigned and no latch is inferred.
        pc_d = pc_q;
        if (rst) begin
            pc_d = RESET_VECTOR;
        end else if (pc_write_en) begin
            // Stored verbatim: alignment and wrap are not this block's concern.
            pc_d = pc_next;
        end
    end

    // The PC register itself; reset is folded into pc_d, so it is synchronous.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignment, so every flop samples its pre-edge
        // inputs regardless of the order of always blocks.
        pc_q <= pc_d;
    end

    assign pc_out = pc_q;

`ifndef SYNTHESIS
    // The PC is undefined until the first reset edge; the stall check below
    // only applies once a reset has been seen.
    logic reset_seen_d;
    logic reset_seen_q;

    // Sticky flag recording that at least one reset edge has occurred.
    always_comb begin
        reset_seen_d = reset_seen_q | rst;
    end

    // Flag register for the assertions only.
    always_ff @(posedge clk) begin
        reset_seen_q <= reset_seen_d;
    end

    // A stalled PC must not move.
    a_stall_holds: assert property (
        @(posedge clk) (reset_seen_q && !rst && !pc_write_en) |=> $stable(pc_out)
    ) else $error("pc_out changed across a stall edge");

    // Any reset edge leaves the PC at the reset vector.
    a_reset_loads_vector: assert property (
        @(posedge clk) rst |=> (pc_out == RESET_VECTOR)
    ) else $error("pc_out is not RESET_VECTOR after a reset edge");
`endif

endmodule : pc_register

// File: tb/tb_pc_register.sv
// Scoreboard bench for pc_register. Two instances share the stimulus: one with
// the default reset vector and one with 32'h8000_0000. The driver pushes the
// values expected after each edge; a monitor pops and compares after the edge.
module tb_pc_register;

    localparam int unsigned    XLEN   = 32;
    localparam logic [XLEN-1:0] RV_A  = 32'h0000_0000;
    localparam logic [XLEN-1:0] RV_B  = 32'h8000_0000;

    logic            clk;
    logic            rst;
    logic            pc_write_en;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] pc_out_a;
    logic [XLEN-1:0] pc_out_b;

    typedef struct {
        string           name;
        logic [XLEN-1:0] exp_a;
        logic [XLEN-1:0] exp_b;
    } exp_t;

    exp_t sb[$];

    int vectors     = 0;
    int miscompares = 0;

    pc_register #(.XLEN(XLEN)) dut_a (
        .clk         (clk),
        .rst         (rst),
        .pc_write_en (pc_write_en),
        .pc_next     (pc_next),
        .pc_out      (pc_out_a)
    );

    pc_register #(.XLEN(XLEN), .RESET_VECTOR(RV_B)) dut_b (
        .clk         (clk),
        .rst         (rst),
        .pc_write_en (pc_write_en),
        .pc_next     (pc_next),
        .pc_out      (pc_out_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [XLEN-1:0] actual,
                         input logic [XLEN-1:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Drive one edge's worth of inputs mid-cycle and queue the post-edge result.
    task automatic step(input string name, input logic r, input logic we,
                        input logic [XLEN-1:0] nxt,
                        input logic [XLEN-1:0] ea, input logic [XLEN-1:0] eb);
        exp_t e;
        @(negedge clk);
        rst         = r;
        pc_write_en = we;
        pc_next     = nxt;
        e.name  = name;
        e.exp_a = ea;
        e.exp_b = eb;
        sb.push_back(e);
    endtask

    // Monitor: the PC is a new output every edge; compare just after it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check({e.name, "/a"}, pc_out_a, e.exp_a);
                check({e.name, "/b"}, pc_out_b, e.exp_b);
            end
        end
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        rst         = 1'b0;
        pc_write_en = 1'b0;
        pc_next     = '0;

        step("reset",        1'b1, 1'b0, 32'h0000_0000, RV_A, RV_B);
        step("load_4",       1'b0, 1'b1, 32'h0000_0004, 32'h0000_0004, 32'h0000_0004);
        step("load_8",       1'b0, 1'b1, 32'h0000_0008, 32'h0000_0008, 32'h0000_0008);
        for (int i = 0; i < 3; i++)
            step("stall",    1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0000_0008, 32'h0000_0008);
        step("stall_x",      1'b0, 1'b0, 'x,            32'h0000_0008, 32'h0000_0008);
        step("rst_priority", 1'b1, 1'b1, 32'h0000_0100, RV_A, RV_B);
        step("load_after_rst", 1'b0, 1'b1, 32'h0000_0100, 32'h0000_0100, 32'h0000_0100);

        // Reset pulsed entirely between two edges must leave the PC alone.
        @(negedge clk);
        pc_write_en = 1'b0;
        pc_next     = 32'h0000_0200;
        rst         = 1'b1;
        #2;
        rst         = 1'b0;
        #1;
        check("sync_rst_mid/a", pc_out_a, 32'h0000_0100);
        check("sync_rst_mid/b", pc_out_b, 32'h0000_0100);
        e.name  = "sync_rst_edge";
        e.exp_a = 32'h0000_0100;
        e.exp_b = 32'h0000_0100;
        sb.push_back(e);

        step("load_fffffffc", 1'b0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
        step("load_3",        1'b0, 1'b1, 32'h0000_0003, 32'h0000_0003, 32'h0000_0003);
        step("load_ffffffff", 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        step("reset_again",   1'b1, 1'b0, 32'h0000_0000, RV_A, RV_B);

        // Let the monitor drain the last expectation, bounded by a few edges.
        for (int i = 0; i < 4 && sb.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        if (sb.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: got %0d pending, expected 0 pending", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_pc_register
